// File: rtl/usb_pkg.sv
// Shared types and constants for the USB full-speed transmit control unit.
// Holds FSM state encoding, PID values, line symbols and CRC parameters.
package usb_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SYNC,
    S_PID,
    S_TOKEN,
    S_CRC5,
    S_DATA,
    S_CRC16,
    S_EOP_SE0,
    S_EOP_J,
    S_DONE
  } tcu_state_t;

  typedef enum logic [1:0] {
    PKT_HANDSHAKE,
    PKT_TOKEN,
    PKT_DATA
  } pkt_kind_t;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  // Line symbols as {dp, dm}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam logic [4:0]  CRC5_POLY  = 5'h05;
  localparam logic [4:0]  CRC5_INIT  = 5'h1F;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  function automatic pkt_kind_t pkt_kind(input logic [3:0] pid);
    case (pid[1:0])
      2'b01:   return PKT_TOKEN;
      2'b11:   return PKT_DATA;
      default: return PKT_HANDSHAKE;
    endcase
  endfunction

  function automatic logic [1:0] nrzi_toggle(input logic [1:0] line);
    return (line == LINE_J) ? LINE_K : LINE_J;
  endfunction

endpackage

// File: rtl/usb_tcu_if.sv
// Request/status and bus-line bundle between host logic and the transmit control unit.
interface usb_tcu_if #(
  parameter int unsigned DATA_BITS = 64
) ();
  logic                 bit_strobe;
  logic                 tx_start;
  logic [3:0]           tx_pid;
  logic [10:0]          tx_token;
  logic [DATA_BITS-1:0] tx_data;
  logic                 dp;
  logic                 dm;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output bit_strobe, tx_start, tx_pid, tx_token, tx_data,
    input  dp, dm, tx_busy, tx_done
  );

  modport slave (
    input  bit_strobe, tx_start, tx_pid, tx_token, tx_data,
    output dp, dm, tx_busy, tx_done
  );
endinterface

// File: rtl/usb_crc_gen.sv
// Serial CRC5/CRC16 engine fed one field bit per enable; exposes the complemented residue.
module usb_crc_gen
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic        crc16_sel,
  input  logic        din,
  output logic [15:0] crc_out
);

  logic [4:0]  crc5_q,  crc5_d;
  logic [15:0] crc16_q, crc16_d;
  logic        fb5, fb16;

  always_comb begin
    crc5_d  = crc5_q;
    crc16_d = crc16_q;
    fb5     = din ^ crc5_q[4];
    fb16    = din ^ crc16_q[15];
    if (clear) begin
      crc5_d  = CRC5_INIT;
      crc16_d = CRC16_INIT;
    end else if (en) begin
      if (crc16_sel) crc16_d = {crc16_q[14:0], 1'b0} ^ (fb16 ? CRC16_POLY : '0);
      else           crc5_d  = {crc5_q[3:0], 1'b0}   ^ (fb5  ? CRC5_POLY  : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc5_q  <= CRC5_INIT;
      crc16_q <= CRC16_INIT;
    end else begin
      crc5_q  <= crc5_d;
      crc16_q <= crc16_d;
    end
  end

  assign crc_out = crc16_sel ? ~crc16_q : {11'b0, ~crc5_q};

endmodule

// File: rtl/usb_tcu.sv
// USB full-speed transmit control unit: serialises SYNC/PID/payload/CRC/EOP with
// bit stuffing and NRZI, one symbol per bit_strobe, onto registered dp/dm.
module usb_tcu
  import usb_pkg::*;
#(
  parameter int unsigned DATA_BITS = 64
) (
  input  logic      clk,
  input  logic      rst,
  usb_tcu_if.slave  bus
);

  localparam int unsigned CNT_W = ($clog2(DATA_BITS + 1) > 5) ? $clog2(DATA_BITS + 1) : 5;
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  typedef logic [CNT_W-1:0] cnt_t;

  tcu_state_t           state_q, state_d;
  cnt_t                 bit_cnt_q, bit_cnt_d;
  logic [2:0]           ones_cnt_q, ones_cnt_d;
  logic [1:0]           line_q, line_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [3:0]           pid_q, pid_d;
  logic [10:0]          token_q, token_d;
  logic [DATA_BITS-1:0] data_q, data_d;

  logic        field_bit, field_last, stuff;
  tcu_state_t  next_field;
  pkt_kind_t   kind;
  logic [7:0]  pid_byte;
  logic        crc_clear, crc_en, crc_sel;
  logic [15:0] crc_out;

  assign kind     = pkt_kind(pid_q);
  assign pid_byte = {~pid_q, pid_q};
  assign crc_sel  = (kind == PKT_DATA);
  assign stuff    = (ones_cnt_q == 3'd6);

  // Current field bit, whether it is the field's last, and the field that follows
  always_comb begin
    field_bit  = 1'b0;
    field_last = 1'b0;
    next_field = S_EOP_SE0;
    case (state_q)
      S_SYNC: begin
        field_bit  = SYNC_BYTE[bit_cnt_q[2:0]];
        field_last = (bit_cnt_q == cnt_t'(7));
        next_field = S_PID;
      end
      S_PID: begin
        field_bit  = pid_byte[bit_cnt_q[2:0]];
        field_last = (bit_cnt_q == cnt_t'(7));
        next_field = (kind == PKT_TOKEN) ? S_TOKEN :
                     (kind == PKT_DATA)  ? S_DATA  : S_EOP_SE0;
      end
      S_TOKEN: begin
        field_bit  = token_q[bit_cnt_q[3:0]];
        field_last = (bit_cnt_q == cnt_t'(10));
        next_field = S_CRC5;
      end
      S_CRC5: begin
        field_bit  = crc_out[4'd4 - bit_cnt_q[3:0]];
        field_last = (bit_cnt_q == cnt_t'(4));
      end
      S_DATA: begin
        field_bit  = data_q[bit_cnt_q[IDX_W-1:0]];
        field_last = (bit_cnt_q == cnt_t'(DATA_BITS - 1));
        next_field = S_CRC16;
      end
      S_CRC16: begin
        field_bit  = crc_out[4'd15 - bit_cnt_q[3:0]];
        field_last = (bit_cnt_q == cnt_t'(15));
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    ones_cnt_d = ones_cnt_q;
    line_d     = line_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pid_d      = pid_q;
    token_d    = token_q;
    data_d     = data_q;
    crc_clear  = 1'b0;
    crc_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The cycle showing tx_done is not yet ready for a new request
        if (bus.tx_start && !done_q) begin
          pid_d      = bus.tx_pid;
          token_d    = bus.tx_token;
          data_d     = bus.tx_data;
          state_d    = S_SYNC;
          busy_d     = 1'b1;
          bit_cnt_d  = '0;
          ones_cnt_d = '0;
          line_d     = LINE_J;
          crc_clear  = 1'b1;
        end
      end
      S_EOP_SE0: begin
        if (bus.bit_strobe) begin
          if (stuff) begin
            line_d     = nrzi_toggle(line_q);
            ones_cnt_d = '0;
          end else begin
            line_d = LINE_SE0;
            if (bit_cnt_q == cnt_t'(1)) begin
              state_d   = S_EOP_J;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + cnt_t'(1);
            end
          end
        end
      end
      S_EOP_J: begin
        if (bus.bit_strobe) begin
          line_d  = LINE_J;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.bit_strobe) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        // Field states: a stuffed 0 preempts the field bit and leaves the counter alone
        if (bus.bit_strobe) begin
          if (stuff) begin
            line_d     = nrzi_toggle(line_q);
            ones_cnt_d = '0;
          end else begin
            line_d     = field_bit ? line_q : nrzi_toggle(line_q);
            ones_cnt_d = field_bit ? (ones_cnt_q + 3'd1) : 3'd0;
            crc_en     = (state_q == S_TOKEN) || (state_q == S_DATA);
            if (field_last) begin
              state_d   = next_field;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + cnt_t'(1);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      ones_cnt_q <= '0;
      line_q     <= LINE_J;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pid_q      <= '0;
      token_q    <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      ones_cnt_q <= ones_cnt_d;
      line_q     <= line_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pid_q      <= pid_d;
      token_q    <= token_d;
      data_q     <= data_d;
    end
  end

  usb_crc_gen u_crc (
    .clk       (clk),
    .rst       (rst),
    .clear     (crc_clear),
    .en        (crc_en),
    .crc16_sel (crc_sel),
    .din       (field_bit),
    .crc_out   (crc_out)
  );

  assign bus.dp      = line_q[1];
  assign bus.dm      = line_q[0];
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

endmodule
